// File: rtl/dma_scheduler.sv
// dma_scheduler: four-channel 8257-class DMA sequencer.
// CPU register port (address/count per channel, mode, status), priority
// arbitration, fixed four-clock byte cycle (S1..S4) with bus hold handshake,
// terminal count handling and channel-2 autoload from channel 3.
// Optional macro DMA_ROTPRI_EN: when defined, mode[4] selects rotating
// priority; when undefined, priority is fixed (ch0 highest) and mode[4] is
// not stored.
module dma_scheduler #(
   parameter int CH_COUNT = 4,
   parameter int ADDR_W   = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [3:0]          iaddr,
   input  logic [7:0]          idata,
   output logic [7:0]          odata,
   input  logic                iwe_n,
   input  logic                ird_n,
   input  logic [CH_COUNT-1:0] drq,
   output logic [CH_COUNT-1:0] dack,
   output logic                hrq,
   input  logic                hlda,
   output logic [ADDR_W-1:0]   oaddr,
   output logic                memr_n,
   output logic                memw_n,
   output logic                tc
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_S1   = 3'd2,
      ST_S2   = 3'd3,
      ST_S3   = 3'd4,
      ST_S4   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic                hrq_q, hrq_d;
   logic [CH_COUNT-1:0] dack_q, dack_d;
   logic                memr_n_q, memr_n_d;
   logic                memw_n_q, memw_n_d;
   logic                tc_q, tc_d;
   logic [ADDR_W-1:0]   oaddr_q, oaddr_d;
   logic [7:0]          odata_q, odata_d;
   logic [1:0]          ch_q, ch_d;
   logic [1:0]          dir_q, dir_d;
   logic                tcz_q, tcz_d;
   logic [CH_COUNT-1:0] en_q, en_d;
   logic                tcstop_q, tcstop_d;
   logic                autold_q, autold_d;
   logic                ff_q, ff_d;
   logic [CH_COUNT-1:0] tcf_q, tcf_d;
   logic                upd_q, upd_d;
   logic                iwe_n_q, iwe_n_d;
   logic                ird_n_q, ird_n_d;
   logic [ADDR_W-1:0]   addr_q [CH_COUNT];
   logic [ADDR_W-1:0]   addr_d [CH_COUNT];
   logic [15:0]         cnt_q  [CH_COUNT];
   logic [15:0]         cnt_d  [CH_COUNT];
`ifdef DMA_ROTPRI_EN
   logic                rot_q, rot_d;
   logic [1:0]          prio_q, prio_d;
`endif

   logic                wr_s, rd_s;
   logic [1:0]          wn_s;
   logic [CH_COUNT-1:0] req_s;
   logic                rot_s;
   logic [1:0]          ptr_s;
   logic [1:0]          win_s;

   // Pick the winning channel; in rotating mode the search starts just after
   // the last-serviced channel so that channel becomes lowest priority.
   function automatic logic [1:0] pick(input logic [3:0] req, input logic rot,
                                       input logic [1:0] ptr);
      logic [1:0] w;
      logic [1:0] j;
      logic       found;
      w     = 2'd0;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (rot) begin
            j = ptr + 2'(i + 1);
         end else begin
            j = 2'(i);
         end
         if (!found && req[j]) begin
            w     = j;
            found = 1'b1;
         end
      end
      return w;
   endfunction

   assign wr_s  = ~iwe_n_q & iwe_n;
   assign rd_s  = ~ird_n_q & ird_n;
   assign wn_s  = iaddr[2:1];
   assign req_s = drq & en_q;
`ifdef DMA_ROTPRI_EN
   assign rot_s = rot_q;
   assign ptr_s = prio_q;
`else
   assign rot_s = 1'b0;
   assign ptr_s = 2'd0;
`endif
   assign win_s = pick(req_s, rot_s, ptr_s);

   // Next-state logic: CPU read side effects, bus-cycle FSM, then CPU writes
   // (applied last so a write wins over the same-cycle S4 update).
   always_comb begin
      state_d  = state_q;
      hrq_d    = hrq_q;
      dack_d   = dack_q;
      memr_n_d = memr_n_q;
      memw_n_d = memw_n_q;
      tc_d     = 1'b0;
      oaddr_d  = oaddr_q;
      ch_d     = ch_q;
      dir_d    = dir_q;
      tcz_d    = tcz_q;
      en_d     = en_q;
      tcstop_d = tcstop_q;
      autold_d = autold_q;
      ff_d     = ff_q;
      tcf_d    = tcf_q;
      upd_d    = upd_q;
      iwe_n_d  = iwe_n;
      ird_n_d  = ird_n;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
`ifdef DMA_ROTPRI_EN
      rot_d    = rot_q;
      prio_d   = prio_q;
`endif

      // read side effects: register reads toggle the byte flip-flop,
      // status read clears the TC flags (a same-cycle TC set below wins)
      if (rd_s) begin
         if (!iaddr[3]) begin
            ff_d = ~ff_q;
         end else if (iaddr == 4'd8) begin
            tcf_d = {CH_COUNT{1'b0}};
         end else begin
            ff_d = ff_q;
         end
      end else begin
         ff_d = ff_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (|req_s) begin
               hrq_d   = 1'b1;
               state_d = ST_WAIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!(|req_s)) begin
               hrq_d   = 1'b0;
               state_d = ST_IDLE;
            end else if (hlda) begin
               state_d = ST_S1;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_S1: begin
            if (|req_s) begin
               ch_d     = win_s;
               dir_d    = cnt_q[win_s][15:14];
               tcz_d    = (cnt_q[win_s][13:0] == 14'd0);
               oaddr_d  = addr_q[win_s];
               dack_d   = CH_COUNT'(1) << win_s;
               memr_n_d = (cnt_q[win_s][15:14] != 2'b10);
               memw_n_d = (cnt_q[win_s][15:14] != 2'b01);
`ifdef DMA_ROTPRI_EN
               prio_d   = win_s;
`endif
               if (win_s == 2'd2) begin
                  upd_d = 1'b0;
               end else begin
                  upd_d = upd_q;
               end
               state_d = ST_S2;
            end else begin
               hrq_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_S2: begin
            state_d = ST_S3;
         end
         ST_S3: begin
            dack_d   = {CH_COUNT{1'b0}};
            memr_n_d = 1'b1;
            memw_n_d = 1'b1;
            tc_d     = tcz_q;
            state_d  = ST_S4;
         end
         ST_S4: begin
            addr_d[ch_q]      = addr_q[ch_q] + ADDR_W'(1);
            cnt_d[ch_q][13:0] = cnt_q[ch_q][13:0] - 14'd1;
            if (tcz_q) begin
               tcf_d[ch_q] = 1'b1;
               if (autold_q && (ch_q == 2'd2)) begin
                  addr_d[2] = addr_q[3];
                  cnt_d[2]  = cnt_q[3];
                  upd_d     = 1'b1;
               end else if (tcstop_q) begin
                  en_d[ch_q] = 1'b0;
               end else begin
                  en_d[ch_q] = en_q[ch_q];
               end
            end else begin
               tcf_d[ch_q] = tcf_d[ch_q];
            end
            if ((|(drq & en_d)) && hlda) begin
               state_d = ST_S1;
            end else begin
               hrq_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            hrq_d    = 1'b0;
            dack_d   = {CH_COUNT{1'b0}};
            memr_n_d = 1'b1;
            memw_n_d = 1'b1;
            state_d  = ST_IDLE;
         end
      endcase

      // CPU register writes, latched on the iwe_n rising edge
      if (wr_s) begin
         if (!iaddr[3]) begin
            if (iaddr[0]) begin
               if (ff_q) cnt_d[wn_s][15:8] = idata;
               else      cnt_d[wn_s][7:0]  = idata;
               if (autold_q && (wn_s == 2'd2)) begin
                  if (ff_q) cnt_d[3][15:8] = idata;
                  else      cnt_d[3][7:0]  = idata;
               end else begin
                  cnt_d[3] = cnt_d[3];
               end
            end else begin
               if (ff_q) addr_d[wn_s][15:8] = idata;
               else      addr_d[wn_s][7:0]  = idata;
               if (autold_q && (wn_s == 2'd2)) begin
                  if (ff_q) addr_d[3][15:8] = idata;
                  else      addr_d[3][7:0]  = idata;
               end else begin
                  addr_d[3] = addr_d[3];
               end
            end
            ff_d = ~ff_q;
         end else if (iaddr == 4'd8) begin
            en_d     = idata[3:0];
            tcstop_d = idata[6];
            autold_d = idata[7];
`ifdef DMA_ROTPRI_EN
            rot_d    = idata[4];
`endif
            ff_d     = 1'b0;
         end else begin
            ff_d = ff_d;
         end
      end else begin
         ff_d = ff_d;
      end

      // CPU read data, registered
      if (!iaddr[3]) begin
         if (iaddr[0]) odata_d = ff_q ? cnt_q[wn_s][15:8]  : cnt_q[wn_s][7:0];
         else          odata_d = ff_q ? addr_q[wn_s][15:8] : addr_q[wn_s][7:0];
      end else if (iaddr == 4'd8) begin
         odata_d = {3'b000, upd_q, tcf_q};
      end else begin
         odata_d = 8'h00;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         hrq_q    <= 1'b0;
         dack_q   <= {CH_COUNT{1'b0}};
         memr_n_q <= 1'b1;
         memw_n_q <= 1'b1;
         tc_q     <= 1'b0;
         oaddr_q  <= {ADDR_W{1'b0}};
         odata_q  <= 8'h00;
         ch_q     <= 2'd0;
         dir_q    <= 2'd0;
         tcz_q    <= 1'b0;
         en_q     <= {CH_COUNT{1'b0}};
         tcstop_q <= 1'b0;
         autold_q <= 1'b0;
         ff_q     <= 1'b0;
         tcf_q    <= {CH_COUNT{1'b0}};
         upd_q    <= 1'b0;
         iwe_n_q  <= 1'b1;
         ird_n_q  <= 1'b1;
         for (int i = 0; i < CH_COUNT; i++) begin
            addr_q[i] <= {ADDR_W{1'b0}};
            cnt_q[i]  <= 16'h0000;
         end
`ifdef DMA_ROTPRI_EN
         rot_q    <= 1'b0;
         prio_q   <= 2'd0;
`endif
      end else begin
         state_q  <= state_d;
         hrq_q    <= hrq_d;
         dack_q   <= dack_d;
         memr_n_q <= memr_n_d;
         memw_n_q <= memw_n_d;
         tc_q     <= tc_d;
         oaddr_q  <= oaddr_d;
         odata_q  <= odata_d;
         ch_q     <= ch_d;
         dir_q    <= dir_d;
         tcz_q    <= tcz_d;
         en_q     <= en_d;
         tcstop_q <= tcstop_d;
         autold_q <= autold_d;
         ff_q     <= ff_d;
         tcf_q    <= tcf_d;
         upd_q    <= upd_d;
         iwe_n_q  <= iwe_n_d;
         ird_n_q  <= ird_n_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
`ifdef DMA_ROTPRI_EN
         rot_q    <= rot_d;
         prio_q   <= prio_d;
`endif
      end
   end

   assign hrq    = hrq_q;
   assign dack   = dack_q;
   assign memr_n = memr_n_q;
   assign memw_n = memw_n_q;
   assign tc     = tc_q;
   assign oaddr  = oaddr_q;
   assign odata  = odata_q;

endmodule

// File: tb/tb_dma_scheduler.sv
// Self-checking bench for dma_scheduler: directed scenarios plus randomized
// programs, compared against a transaction-level model of the channel rules.
module tb_dma_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  iaddr = 4'd0;
   logic [7:0]  idata = 8'h00;
   logic [7:0]  odata;
   logic        iwe_n = 1'b1;
   logic        ird_n = 1'b1;
   logic [3:0]  drq = 4'b0000;
   logic [3:0]  dack;
   logic        hrq;
   logic        hlda = 1'b0;
   logic [15:0] oaddr;
   logic        memr_n, memw_n, tc;
   logic        hlda_en = 1'b1;

   int n_checks = 0;
   int n_err    = 0;

   // reference model state
   logic [15:0] m_addr [4];
   logic [15:0] m_cnt  [4];
   logic [3:0]  m_en, m_tcf;
   logic        m_rot, m_tcstop, m_autold, m_ff, m_upd;
   int          m_ptr;

   dma_scheduler #(.CH_COUNT(4), .ADDR_W(16)) dut (
      .clk(clk), .reset(reset), .iaddr(iaddr), .idata(idata), .odata(odata),
      .iwe_n(iwe_n), .ird_n(ird_n), .drq(drq), .dack(dack), .hrq(hrq),
      .hlda(hlda), .oaddr(oaddr), .memr_n(memr_n), .memw_n(memw_n), .tc(tc)
   );

   always #5 clk = ~clk;

   // bus owner grants hold one clock after the request
   always @(negedge clk) hlda = hrq & hlda_en;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < 4; i++) begin
         m_addr[i] = 16'h0000;
         m_cnt[i]  = 16'h0000;
      end
      m_en = 4'b0000; m_tcf = 4'b0000;
      m_rot = 1'b0; m_tcstop = 1'b0; m_autold = 1'b0; m_ff = 1'b0; m_upd = 1'b0;
      m_ptr = 0;
   endfunction

   function automatic int m_pick(input logic [3:0] req);
      int j;
      for (int i = 0; i < 4; i++) begin
         j = m_rot ? (m_ptr + 1 + i) % 4 : i;
         if (req[j]) return j;
      end
      return 0;
   endfunction

   // effect of one completed byte transfer on channel w
   function automatic void m_commit(input int w, input logic t);
      m_ptr = w;
      if (w == 2) m_upd = 1'b0;
      m_addr[w] = m_addr[w] + 16'd1;
      m_cnt[w][13:0] = m_cnt[w][13:0] - 14'd1;
      if (t) begin
         m_tcf[w] = 1'b1;
         if (m_autold && w == 2) begin
            m_addr[2] = m_addr[3];
            m_cnt[2]  = m_cnt[3];
            m_upd     = 1'b1;
         end else if (m_tcstop) begin
            m_en[w] = 1'b0;
         end
      end
   endfunction

   task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
      int n;
      @(negedge clk);
      iaddr = a; idata = d; iwe_n = 1'b0;
      @(negedge clk);
      iwe_n = 1'b1;
      @(negedge clk);
      if (a < 4'd8) begin
         n = int'(a) / 2;
         for (int k = 0; k < 2; k++) begin
            int t;
            t = (k == 0) ? n : 3;
            if (k == 0 || (m_autold && n == 2)) begin
               if (a[0]) begin
                  if (m_ff) m_cnt[t][15:8] = d; else m_cnt[t][7:0] = d;
               end else begin
                  if (m_ff) m_addr[t][15:8] = d; else m_addr[t][7:0] = d;
               end
            end
         end
         m_ff = ~m_ff;
      end else if (a == 4'd8) begin
         m_en = d[3:0];
`ifdef DMA_ROTPRI_EN
         m_rot = d[4];
`else
         m_rot = 1'b0;
`endif
         m_tcstop = d[6];
         m_autold = d[7];
         m_ff = 1'b0;
      end
   endtask

   task automatic cpu_rd(input logic [3:0] a, input string tag);
      logic [7:0]  exp;
      logic [15:0] r;
      int n;
      exp = 8'h00;
      if (a < 4'd8) begin
         n = int'(a) / 2;
         r = a[0] ? m_cnt[n] : m_addr[n];
         exp = m_ff ? r[15:8] : r[7:0];
      end else if (a == 4'd8) begin
         exp = {3'b000, m_upd, m_tcf};
      end
      @(negedge clk);
      iaddr = a; ird_n = 1'b0;
      @(negedge clk);
      check(tag, odata, exp);
      ird_n = 1'b1;
      @(negedge clk);
      if (a < 4'd8) m_ff = ~m_ff;
      else if (a == 4'd8) m_tcf = 4'b0000;
   endtask

   task automatic prog_ch(input int ch, input logic [15:0] a, input logic [15:0] c);
      cpu_wr(4'(2 * ch), a[7:0]);
      cpu_wr(4'(2 * ch), a[15:8]);
      cpu_wr(4'(2 * ch + 1), c[7:0]);
      cpu_wr(4'(2 * ch + 1), c[15:8]);
   endtask

   // hold a drq pattern and check up to n byte cycles against the model
   task automatic run(input logic [3:0] pattern, input int n, input bit keep);
      int got, cyc, last, w;
      logic [15:0] a;
      logic [1:0]  dir;
      logic        t, er, ew;
      got = 0; cyc = 0; last = 0;
      drq = pattern;
      while (got < n && cyc < 400 && (drq & m_en) != 4'b0000) begin
         @(negedge clk); cyc++;
         if (dack != 4'b0000) begin
            w   = m_pick(drq & m_en);
            a   = m_addr[w];
            dir = m_cnt[w][15:14];
            t   = (m_cnt[w][13:0] == 14'd0);
            er  = (dir != 2'b10);
            ew  = (dir != 2'b01);
            m_commit(w, t);
            check("s2_dack", dack, 32'(1 << w));
            check("s2_oaddr", oaddr, a);
            check("s2_strobes", {memr_n, memw_n}, {er, ew});
            if (got > 0) check("cycle_gap", cyc - last, 4);
            last = cyc;
            @(negedge clk); cyc++;
            check("s3_hold", {dack, memr_n, memw_n}, {4'(1 << w), er, ew});
            @(negedge clk); cyc++;
            check("s4_tc", tc, t);
            check("s4_release", {dack, memr_n, memw_n}, {4'b0000, 1'b1, 1'b1});
            got++;
            if (got == n && !keep) drq = 4'b0000;
         end
      end
      if (got != n && (drq & m_en) == 4'b0000) begin
         repeat (3) @(negedge clk);
         check("halt_hrq", hrq, 1'b0);
      end else begin
         check("xfer_count", got, n);
      end
      drq = 4'b0000;
      repeat (3) @(negedge clk);
      check("idle_hrq", hrq, 1'b0);
   endtask

   initial begin
      int cyc;
      m_reset();
      // reset state
      repeat (3) @(negedge clk);
      check("rst_hrq", hrq, 1'b0);
      check("rst_dack", dack, 4'b0000);
      check("rst_strobes", {memr_n, memw_n, tc}, 3'b110);
      check("rst_oaddr", oaddr, 16'h0000);
      reset = 1'b0;
      cpu_rd(4'd8, "rst_status");
      cpu_rd(4'd0, "rst_addr0");

      // 1: four-byte read on ch2, TC on the last one
      cpu_wr(4'd8, 8'h04);
      prog_ch(2, 16'h76D0, 16'h8003);
      run(4'b0100, 4, 1'b0);
      cpu_rd(4'd8, "t1_status");
      cpu_rd(4'd8, "t1_status_clr");

      // 2: autoload from ch3 shadow
      cpu_wr(4'd8, 8'h84);
      prog_ch(2, 16'h1000, 16'h8001);
      run(4'b0100, 2, 1'b0);
      cpu_rd(4'd8, "t2_status");
      cpu_rd(4'd4, "t2_addr_lo");
      cpu_rd(4'd4, "t2_addr_hi");
      run(4'b0100, 1, 1'b0);
      cpu_rd(4'd8, "t2_upd_clr");

      // 3: fixed priority
      cpu_wr(4'd8, 8'h06);
      prog_ch(1, 16'h2000, 16'h8005);
      prog_ch(2, 16'h3000, 16'h4005);
      run(4'b0110, 3, 1'b0);

      // 4: rotating priority when built in, fixed otherwise
      cpu_wr(4'd8, 8'h16);
      run(4'b0110, 4, 1'b0);

      // 6: TC-stop on a single write byte
      cpu_wr(4'd8, 8'h42);
      prog_ch(1, 16'h5555, 16'h4000);
      run(4'b0010, 3, 1'b1);
      cpu_rd(4'd8, "t6_status");

      // 5: reset in the middle of S3
      cpu_wr(4'd8, 8'h01);
      prog_ch(0, 16'h0100, 16'h8003);
      drq = 4'b0001;
      cyc = 0;
      while (dack == 4'b0000 && cyc < 50) begin
         @(negedge clk); cyc++;
      end
      check("t5_start", dack, 4'b0001);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("t5_hrq", hrq, 1'b0);
      check("t5_dack", dack, 4'b0000);
      check("t5_strobes", {memr_n, memw_n, tc}, 3'b110);
      check("t5_oaddr", oaddr, 16'h0000);
      reset = 1'b0;
      m_reset();
      repeat (3) @(negedge clk);
      check("t5_idle", hrq, 1'b0);
      drq = 4'b0000;
      cpu_rd(4'd8, "t5_status");

      // randomized programs
      for (int r = 0; r < 12; r++) begin
         logic [7:0] md;
         md = 8'($urandom);
         cpu_wr(4'd8, md);
         for (int c = 0; c < 4; c++)
            prog_ch(c, 16'($urandom), {2'($urandom), 12'h000, 2'($urandom)});
         run(4'($urandom), $urandom_range(1, 6), 1'b0);
         cpu_rd(4'd8, "rnd_status");
         cpu_rd(4'($urandom_range(0, 7)), "rnd_reg");
         cpu_rd(4'($urandom_range(9, 15)), "rnd_unmapped");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
